// File: rtl/codigo_junto.sv
// codigo_junto: four-candidate election tallier.
// Registers the four ID codes and vote counts, picks the slot with the most
// votes (ties resolve to the earliest slot A..D), and registers that slot's
// ID code plus a "second round required" flag when the winner lacks an
// absolute majority of the total.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   A..D        2-bit ID code carried by each candidate slot
//   VA..VD      6-bit unsigned vote count per slot
//   Candidato1  registered ID code of the winning slot
//   Candidato2  registered flag, 1 = no absolute majority (second round)
module codigo_junto (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic [1:0] C,
    input  logic [1:0] D,
    input  logic [5:0] VA,
    input  logic [5:0] VB,
    input  logic [5:0] VC,
    input  logic [5:0] VD,
    output logic [1:0] Candidato1,
    output logic       Candidato2
);

    localparam int unsigned IdW    = 2;
    localparam int unsigned VoteW  = 6;
    localparam int unsigned TotalW = 8;
    localparam int unsigned CmpW   = 9;

    // Stage 1: captured inputs
    logic [IdW-1:0]   a_q, b_q, c_q, d_q;
    logic [VoteW-1:0] va_q, vb_q, vc_q, vd_q;
    // Marks stage 1 as holding real inputs; keeps stage 2 at reset values
    // for the first edge after reset releases.
    logic             valid_q;

    // Stage 2: registered result
    logic [IdW-1:0]   cand1_q, cand1_d;
    logic             cand2_q, cand2_d;

    // Combinational winner search and majority test
    logic [IdW-1:0]    win_id;
    logic [VoteW-1:0]  win_v;
    logic [TotalW-1:0] total;
    logic              majority;

    // Stage 1 register
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            va_q    <= '0;
            vb_q    <= '0;
            vc_q    <= '0;
            vd_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= A;
            b_q     <= B;
            c_q     <= C;
            d_q     <= D;
            va_q    <= VA;
            vb_q    <= VB;
            vc_q    <= VC;
            vd_q    <= VD;
            valid_q <= 1'b1;
        end
    end

    // Winner selection: strict greater-than so earlier slots keep ties
    always_comb begin
        win_id = a_q;
        win_v  = va_q;
        if (vb_q > win_v) begin
            win_id = b_q;
            win_v  = vb_q;
        end
        if (vc_q > win_v) begin
            win_id = c_q;
            win_v  = vc_q;
        end
        if (vd_q > win_v) begin
            win_id = d_q;
            win_v  = vd_q;
        end
    end

    // Total fits in 8 bits (max 252); doubled winner compared at 9 bits
    always_comb begin
        total    = TotalW'(va_q) + TotalW'(vb_q) + TotalW'(vc_q) + TotalW'(vd_q);
        majority = (CmpW'({win_v, 1'b0}) > CmpW'(total));
    end

    // Stage 2 next-state
    always_comb begin
        cand1_d = '0;
        cand2_d = 1'b0;
        if (valid_q) begin
            cand1_d = win_id;
            cand2_d = ~majority;
        end
    end

    // Stage 2 register
    always_ff @(posedge clk) begin
        if (rst) begin
            cand1_q <= '0;
            cand2_q <= 1'b0;
        end else begin
            cand1_q <= cand1_d;
            cand2_q <= cand2_d;
        end
    end

    assign Candidato1 = cand1_q;
    assign Candidato2 = cand2_q;

endmodule

// File: tb/tb_codigo_junto.sv
// Testbench for codigo_junto: table of directed vectors streamed back to
// back, a random stream checked against a reference function, and reset
// sequences. Expected results are queued with the cycle they are due.
module tb_codigo_junto;

    logic       clk;
    logic       rst;
    logic [1:0] A, B, C, D;
    logic [5:0] VA, VB, VC, VD;
    logic [1:0] Candidato1;
    logic       Candidato2;

    codigo_junto dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .VA        (VA),
        .VB        (VB),
        .VC        (VC),
        .VD        (VD),
        .Candidato1(Candidato1),
        .Candidato2(Candidato2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] a, b, c, d;
        logic [5:0] va, vb, vc, vd;
        logic [1:0] c1;
        logic       c2;
    } vec_t;

    typedef struct {
        int         due;
        int         tag;
        logic [1:0] c1;
        logic       c2;
    } sb_t;

    sb_t  sbq[$];
    int   cyc     = 0;
    int   n_total = 0;
    int   n_pass  = 0;
    vec_t tbl[9];

    // Reference: max with earliest-slot tie break, majority if 2*Vw > total
    function automatic vec_t model(input vec_t v);
        vec_t       r;
        logic [5:0] cnt[4];
        logic [1:0] ids[4];
        int         w;
        int         tot;
        r      = v;
        cnt[0] = v.va; cnt[1] = v.vb; cnt[2] = v.vc; cnt[3] = v.vd;
        ids[0] = v.a;  ids[1] = v.b;  ids[2] = v.c;  ids[3] = v.d;
        w = 0;
        for (int i = 1; i < 4; i++)
            if (cnt[i] > cnt[w]) w = i;
        tot  = int'(v.va) + int'(v.vb) + int'(v.vc) + int'(v.vd);
        r.c1 = ids[w];
        r.c2 = !((2 * int'(cnt[w])) > tot);
        return r;
    endfunction

    // Compare every entry due this cycle against the sampled outputs
    task automatic check_due();
        sb_t e;
        while (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            n_total++;
            if (Candidato1 === e.c1 && Candidato2 === e.c2) begin
                n_pass++;
            end else begin
                $display("FAIL result tag=%0d cyc=%0d: got Candidato1=%b Candidato2=%b, want Candidato1=%b Candidato2=%b",
                         e.tag, cyc, Candidato1, Candidato2, e.c1, e.c2);
            end
        end
    endtask

    // One cycle: sample on the falling edge, then drive and enqueue
    task automatic step(input logic r, input vec_t v, input int tag);
        sb_t e;
        @(negedge clk);
        cyc++;
        check_due();
        rst = r;
        A = v.a;   B = v.b;   C = v.c;   D = v.d;
        VA = v.va; VB = v.vb; VC = v.vc; VD = v.vd;
        if (r) begin
            // Reset clears both stages: next two samples show reset values
            while (sbq.size() > 0) void'(sbq.pop_back());
            e.tag = tag; e.c1 = 2'b00; e.c2 = 1'b0;
            e.due = cyc + 1; sbq.push_back(e);
            e.due = cyc + 2; sbq.push_back(e);
        end else begin
            e.tag = tag; e.c1 = v.c1; e.c2 = v.c2; e.due = cyc + 2;
            sbq.push_back(e);
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.a  = 2'($urandom_range(0, 3));
        v.b  = 2'($urandom_range(0, 3));
        v.c  = 2'($urandom_range(0, 3));
        v.d  = 2'($urandom_range(0, 3));
        // Narrow range sometimes to provoke ties
        if ($urandom_range(0, 1) == 0) begin
            v.va = 6'($urandom_range(0, 3));
            v.vb = 6'($urandom_range(0, 3));
            v.vc = 6'($urandom_range(0, 3));
            v.vd = 6'($urandom_range(0, 3));
        end else begin
            v.va = 6'($urandom_range(0, 63));
            v.vb = 6'($urandom_range(0, 63));
            v.vc = 6'($urandom_range(0, 63));
            v.vd = 6'($urandom_range(0, 63));
        end
        v.c1 = 2'b00;
        v.c2 = 1'b0;
        return model(v);
    endfunction

    initial begin
        vec_t v;
        // {a, b, c, d, va, vb, vc, vd, expected Candidato1, expected Candidato2}
        tbl[0] = '{2'd0, 2'd1, 2'd2, 2'd3, 6'd17, 6'd15, 6'd15, 6'd53, 2'd3, 1'b0};
        tbl[1] = '{2'd0, 2'd1, 2'd2, 2'd3, 6'd30, 6'd25, 6'd25, 6'd20, 2'd0, 1'b1};
        tbl[2] = '{2'd0, 2'd1, 2'd2, 2'd3, 6'd10, 6'd20, 6'd20, 6'd0,  2'd1, 1'b1};
        tbl[3] = '{2'd0, 2'd1, 2'd2, 2'd3, 6'd0,  6'd32, 6'd32, 6'd0,  2'd1, 1'b1};
        tbl[4] = '{2'd0, 2'd1, 2'd2, 2'd3, 6'd0,  6'd0,  6'd0,  6'd0,  2'd0, 1'b1};
        tbl[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 6'd63, 6'd63, 6'd63, 6'd63, 2'd0, 1'b1};
        tbl[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 6'd0,  6'd0,  6'd0,  6'd63, 2'd3, 1'b0};
        tbl[7] = '{2'd3, 2'd2, 2'd1, 2'd0, 6'd5,  6'd40, 6'd5,  6'd5,  2'd2, 1'b0};
        tbl[8] = '{2'd2, 2'd2, 2'd1, 2'd1, 6'd1,  6'd0,  6'd40, 6'd0,  2'd1, 1'b0};

        rst = 1'b1;
        A = '0; B = '0; C = '0; D = '0;
        VA = '0; VB = '0; VC = '0; VD = '0;

        // Reset for two cycles with arbitrary inputs, then stream the table
        step(1'b1, tbl[0], 100);
        step(1'b1, tbl[5], 101);
        for (int i = 0; i < 9; i++) step(1'b0, tbl[i], i);

        // Each directed vector held alone so it settles in isolation
        for (int i = 0; i < 9; i++) begin
            step(1'b0, tbl[i], 10 + i);
            step(1'b0, tbl[i], 10 + i);
        end

        // Random stream, new inputs every cycle
        for (int i = 0; i < 40; i++) begin
            v = rand_vec();
            step(1'b0, v, 200 + i);
        end

        // Reset mid-stream: outputs clear on the next edge and stay cleared
        // until two edges after release
        step(1'b0, tbl[0], 300);
        step(1'b0, tbl[7], 301);
        step(1'b1, tbl[6], 302);
        step(1'b0, tbl[7], 303);
        step(1'b0, tbl[1], 304);
        step(1'b0, tbl[0], 305);

        // Single-cycle reset pulse in the middle of random traffic
        for (int i = 0; i < 6; i++) begin
            v = rand_vec();
            step((i == 3) ? 1'b1 : 1'b0, v, 400 + i);
        end

        // Drain the scoreboard
        for (int i = 0; i < 4; i++) step(1'b0, tbl[4], 500 + i);
        while (sbq.size() > 0 && sbq[0].due > cyc + 2) void'(sbq.pop_front());
        for (int i = 0; i < 3 && sbq.size() > 0; i++) begin
            @(negedge clk);
            cyc++;
            check_due();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
